// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: function codes, FSM states
// and the number of logarithmic stages.
package shift_pkg;

  localparam int unsigned STAGES = 5;

  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One stage of the logarithmic shifter: shifts by 2^k when enabled, with the
// fill selected by the function code.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned KW      = 3
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [KW-1:0]    i_k,
  input  logic             i_en,
  input  logic [5:0]       i_op,
  output logic [WIDTH-1:0] o_value
);

  logic [SHAMT_W-1:0] w_dist;

  assign w_dist = SHAMT_W'(1) << i_k;

  // Apply the 2^k shift for this stage, or pass the value through.
  always_comb begin
    o_value = i_value;
    if (i_en) begin
      case (i_op)
        SLL:     o_value = i_value << w_dist;
        SRL:     o_value = i_value >> w_dist;
        SRA:     o_value = $signed(i_value) >>> w_dist;
        default: o_value = i_value;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: walks one binary shift stage per clock and
// returns the registered result with a done pulse.
// Optional early completion when the remaining amount bits are zero: SHIFT_EARLY_DONE_EN.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] dataOut
);

  localparam int unsigned KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [SHAMT_W-1:0] r_amt, w_amt_nxt;
  logic [5:0]         r_op, w_op_nxt;
  logic [KW-1:0]      r_k, w_k_nxt;
  logic [WIDTH-1:0]   r_dout, w_dout_nxt;
  logic               r_illegal, w_illegal_nxt;

  logic [WIDTH-1:0]   w_stage_out;
  logic               w_last_stage;

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .KW      (KW)
  ) u_stage (
    .i_value (r_acc),
    .i_k     (r_k),
    .i_en    (r_amt[r_k]),
    .i_op    (r_op),
    .o_value (w_stage_out)
  );

`ifdef SHIFT_EARLY_DONE_EN
  // Finish as soon as no higher amount bits remain to be applied.
  assign w_last_stage = (r_k == KW'(SHAMT_W - 1)) || (((r_amt >> r_k) >> 1) == '0);
`else
  assign w_last_stage = (r_k == KW'(SHAMT_W - 1));
`endif

  // Next-state logic: accept in IDLE/DONE, one stage per cycle in SHIFT.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_amt_nxt     = r_amt;
    w_op_nxt      = r_op;
    w_k_nxt       = r_k;
    w_dout_nxt    = r_dout;
    w_illegal_nxt = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_acc_nxt = dataA;
          w_amt_nxt = dataB[SHAMT_W-1:0];
          w_op_nxt  = Signal;
          w_k_nxt   = '0;
          if (is_legal_op(Signal)) begin
            w_state_nxt = StShift;
          end else begin
            // Unsupported code: echo the operand and flag it, no shift phase.
            w_state_nxt   = StDone;
            w_dout_nxt    = dataA;
            w_illegal_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StShift: begin
        w_acc_nxt = w_stage_out;
        w_k_nxt   = r_k + KW'(1);
        if (w_last_stage) begin
          w_dout_nxt  = w_stage_out;
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_amt     <= '0;
      r_op      <= '0;
      r_k       <= '0;
      r_dout    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_amt     <= w_amt_nxt;
      r_op      <= w_op_nxt;
      r_k       <= w_k_nxt;
      r_dout    <= w_dout_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign busy    = (r_state == StShift);
  assign done    = (r_state == StDone);
  assign illegal = r_illegal;
  assign dataOut = r_dout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// requests against a whole-shift reference model.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic        busy, done, illegal;
  logic [31:0] dataOut;

  int n_cmp = 0;
  int n_err = 0;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole shift in one step, straight from the function-code rules.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] sig);
    int n;
    n = b % 32;
    if (sig == 6'b000000) return a << n;
    if (sig == 6'b000010) return a >> n;
    if (sig == 6'b000011) return $signed(a) >>> n;
    return a;
  endfunction

  function automatic logic ref_legal(input logic [5:0] sig);
    return (sig == 6'b000000) || (sig == 6'b000010) || (sig == 6'b000011);
  endfunction

  // Number of busy cycles expected for a request.
  function automatic int ref_cycles(input logic [31:0] b, input logic [5:0] sig);
    int n;
    int c;
    if (!ref_legal(sig)) return 0;
`ifdef SHIFT_EARLY_DONE_EN
    n = b % 32;
    c = 1;
    while ((n >> c) != 0) c++;
    return c;
`else
    n = b % 32;
    c = (n >= 0) ? 5 : 5;
    return c;
`endif
  endfunction

  // Issue one request (from IDLE or DONE) and wait for its done pulse.
  task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                                output int cycles, output logic got_done,
                                output logic [31:0] dout, output logic ill);
    dataA  = a;
    dataB  = b;
    Signal = sig;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    cycles   = 0;
    got_done = 1'b0;
    dout     = 'x;
    ill      = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got_done = 1'b1;
        dout     = dataOut;
        ill      = illegal;
        break;
      end
      if (busy) cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++;
    if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal); end
    n_cmp++;
    if (dataOut !== 32'h0) begin n_err++; $display("FAIL reset_dataOut got %h want 0", dataOut); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] a_t [4] = '{32'h8000_0000, 32'hF000_0000, 32'h0000_0001, 32'h0000_00F0};
    logic [31:0] b_t [4] = '{32'd31, 32'd4, 32'd31, 32'hFFFF_FFE3};
    logic [5:0]  s_t [4] = '{SRL, SRA, SLL, SRL};
    logic [31:0] e_t [4] = '{32'h0000_0001, 32'hFF00_0000, 32'h8000_0000, 32'h0000_001E};
    int cyc;
    logic gd, ill;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      issue_and_wait(a_t[i], b_t[i], s_t[i], cyc, gd, d, ill);
      n_cmp++; if (gd !== 1'b1) begin n_err++; $display("FAIL dir%0d_done got %b want 1", i, gd); end
      n_cmp++; if (d !== e_t[i]) begin n_err++; $display("FAIL dir%0d_data got %h want %h", i, d, e_t[i]); end
      n_cmp++; if (ill !== 1'b0) begin n_err++; $display("FAIL dir%0d_illegal got %b want 0", i, ill); end
      n_cmp++;
      if (cyc != ref_cycles(b_t[i], s_t[i])) begin
        n_err++; $display("FAIL dir%0d_busy got %0d want %0d", i, cyc, ref_cycles(b_t[i], s_t[i]));
      end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_illegal();
    int cyc;
    logic gd, ill;
    logic [31:0] d;
    issue_and_wait(32'h0000_1234, 32'd7, 6'b100000, cyc, gd, d, ill);
    n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL ill_busy got %0d want 0", cyc); end
    n_cmp++; if (gd !== 1'b1) begin n_err++; $display("FAIL ill_done got %b want 1", gd); end
    n_cmp++; if (ill !== 1'b1) begin n_err++; $display("FAIL ill_flag got %b want 1", ill); end
    n_cmp++; if (d !== 32'h0000_1234) begin n_err++; $display("FAIL ill_data got %h want 1234", d); end
    tick();
    n_cmp++;
    if ({done, illegal} !== 2'b00) begin
      n_err++; $display("FAIL ill_clear got %b want 00", {done, illegal});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic gd, ill;
    logic [31:0] d;
    dataA = 32'h8000_0000; dataB = 32'd31; Signal = SRL; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Ignored start during the shift phase.
    dataA = 32'hDEAD_BEEF; dataB = 32'd1; Signal = SLL; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 2;
    gd  = 1'b0;
    for (int i = 0; i < 20 && !gd; i++) begin
      if (done) gd = 1'b1;
      else begin
        if (busy) cyc++;
        tick();
      end
    end
    n_cmp++; if (gd !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b want 1", gd); end
    n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL b2b_first_busy got %0d want 5", cyc); end
    n_cmp++;
    if (dataOut !== 32'h1) begin n_err++; $display("FAIL b2b_first_data got %h want 1", dataOut); end
    // Still in the DONE cycle: next request accepted without a bubble.
    issue_and_wait(32'h3, 32'd1, SLL, cyc, gd, d, ill);
    n_cmp++; if (gd !== 1'b1) begin n_err++; $display("FAIL b2b_second_done got %b want 1", gd); end
    n_cmp++; if (d !== 32'h6) begin n_err++; $display("FAIL b2b_second_data got %h want 6", d); end
    n_cmp++;
    if (cyc != ref_cycles(32'd1, SLL)) begin
      n_err++; $display("FAIL b2b_second_busy got %0d want %0d", cyc, ref_cycles(32'd1, SLL));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    dataA = 32'h0000_00FF; dataB = 32'd31; Signal = SLL; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({busy, done, illegal} !== 3'b000 || dataOut !== 32'h0) begin
      n_err++;
      $display("FAIL rmid_outputs got %b/%h want 000/0", {busy, done, illegal}, dataOut);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rmid_abandon got %0d want 0", seen); end
  endtask

  task automatic test_early();
    int cyc;
    logic gd, ill;
    logic [31:0] d;
    logic [31:0] b_t [3] = '{32'd0, 32'd2, 32'd17};
    for (int i = 0; i < 3; i++) begin
      issue_and_wait(32'hA5A5_0F0F, b_t[i], SRL, cyc, gd, d, ill);
      n_cmp++;
      if (cyc != ref_cycles(b_t[i], SRL)) begin
        n_err++; $display("FAIL early%0d_busy got %0d want %0d", i, cyc, ref_cycles(b_t[i], SRL));
      end
      n_cmp++;
      if (d !== ref_result(32'hA5A5_0F0F, b_t[i], SRL)) begin
        n_err++;
        $display("FAIL early%0d_data got %h want %h", i, d, ref_result(32'hA5A5_0F0F, b_t[i], SRL));
      end
      tick();
    end
  endtask

  task automatic test_random();
    int cyc;
    logic gd, ill;
    logic [31:0] d, a, b;
    logic [5:0] s;
    for (int i = 0; i < 60; i++) begin
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 6))
        0, 1:    s = SLL;
        2, 3:    s = SRL;
        4, 5:    s = SRA;
        default: s = {1'b1, 5'($urandom())};
      endcase
      issue_and_wait(a, b, s, cyc, gd, d, ill);
      n_cmp++;
      if (gd !== 1'b1 || d !== ref_result(a, b, s) || ill !== !ref_legal(s)
          || cyc != ref_cycles(b, s)) begin
        n_err++;
        $display("FAIL rand%0d got done=%b data=%h ill=%b busy=%0d want done=1 data=%h ill=%b busy=%0d",
                 i, gd, d, ill, cyc, ref_result(a, b, s), !ref_legal(s), ref_cycles(b, s));
      end
      // Randomly leave a gap or go straight back-to-back from DONE.
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_early();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
